window_stream_ctrl: RTL and testbench

- Sequences the pixel-word stream into the 3-row line-buffer window datapath (2-word taps per row, 76-word delay lines, 78-word lines).
- Generates the datapath write_en and tracks row/column position.
- Qualifies which datapath window outputs w0..w5 are complete, and presents them downstream with valid/ready handshaking and frame framing.
- Sits between the input pixel source and the edge-detection kernel.

---
 rtl/window_stream_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_window_stream_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_stream_ctrl.sv
// -----------------------------------------------------------------------------
// window_stream_ctrl
//   Sequences a pixel-word stream into the 3-row line-buffer window datapath.
//   It drives the datapath shift enable and tracks the row/column of the next
//   write. It marks which datapath windows are complete and hands them
//   downstream with valid/ready handshaking and frame framing.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   in_valid, in_sof   input word available / word is pixel (0,0)
//   in_ready           controller accepts the input word this cycle
//   write_en           datapath shift enable (combinational)
//   out_valid          datapath window w0..w5 is complete and held
//   out_ready          downstream consumes the window
//   out_row, out_col   position of the newest word in the window
//   out_last           final window of the frame
//   frame_done         one-cycle pulse after the last window is consumed
//   sof_err            sticky: in_sof seen mid-frame (cleared by rst only)
//   stat_drop          words discarded in IDLE, saturating (optional)
//   stat_frames        frame_done pulses, saturating (optional)
//
// Optional feature macro: WINDOW_STREAM_CTRL_STATS_EN enables the stat_* ports.
// -----------------------------------------------------------------------------
module window_stream_ctrl #(
  parameter int IMG_WIDTH  = 78,
  parameter int IMG_HEIGHT = 64,
  parameter int COL_W      = 7,
  parameter int ROW_W      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic             write_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             out_last,
  output logic             frame_done,
  output logic             sof_err
`ifdef WINDOW_STREAM_CTRL_STATS_EN
  ,
  output logic [15:0]      stat_drop,
  output logic [15:0]      stat_frames
`endif
);

  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  // First row whose writes complete a 3-row window.
  localparam logic [ROW_W-1:0] WIN_ROW  = ROW_W'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;
  logic             out_valid_r;
  logic [ROW_W-1:0] out_row_r;
  logic [COL_W-1:0] out_col_r;
  logic             out_last_r;
  logic             frame_done_r;
  logic             sof_err_r;

  logic             in_ready_s;
  logic             write_s;
  logic [ROW_W-1:0] wr_row_s;
  logic [COL_W-1:0] wr_col_s;
  logic [ROW_W-1:0] nxt_row_s;
  logic [COL_W-1:0] nxt_col_s;
  logic             frame_end_s;
  logic             qual_s;
  logic             consume_s;

  // Handshake, write position and window qualification for the current cycle.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      ACTIVE:  in_ready_s = ~out_valid_r | out_ready;
      DRAIN:   in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase

    // IDLE discards non-sof words, so only sof (or any ACTIVE word) shifts.
    write_s = in_valid & in_ready_s & ((state_r != IDLE) | in_sof);

    // A sof word always lands at (0,0), even when it restarts a frame.
    if (in_sof) begin
      wr_row_s = ROW_ZERO;
      wr_col_s = COL_ZERO;
    end else begin
      wr_row_s = row_r;
      wr_col_s = col_r;
    end

    if (wr_col_s == LAST_COL) begin
      nxt_col_s = COL_ZERO;
      nxt_row_s = wr_row_s + ROW_ONE;
    end else begin
      nxt_col_s = wr_col_s + COL_ONE;
      nxt_row_s = wr_row_s;
    end

    frame_end_s = (wr_row_s == LAST_ROW) & (wr_col_s == LAST_COL);
    // Column 0 would straddle a line boundary; rows 0-1 lack a full window.
    qual_s      = write_s & (wr_row_s >= WIN_ROW) & (wr_col_s != COL_ZERO);
    consume_s   = out_valid_r & out_ready;
  end

  // Frame sequencing FSM with row/column position and error tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      row_r        <= ROW_ZERO;
      col_r        <= COL_ZERO;
      frame_done_r <= 1'b0;
      sof_err_r    <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (write_s) begin
            state_r <= ACTIVE;
            row_r   <= nxt_row_s;
            col_r   <= nxt_col_s;
          end
        end
        ACTIVE: begin
          if (write_s) begin
            if (in_sof && ((row_r != ROW_ZERO) || (col_r != COL_ZERO))) begin
              sof_err_r <= 1'b1;
            end
            if (frame_end_s) begin
              state_r <= DRAIN;
              row_r   <= ROW_ZERO;
              col_r   <= COL_ZERO;
            end else begin
              row_r   <= nxt_row_s;
              col_r   <= nxt_col_s;
            end
          end
        end
        DRAIN: begin
          if (consume_s && out_last_r) begin
            state_r      <= IDLE;
            frame_done_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          row_r   <= ROW_ZERO;
          col_r   <= COL_ZERO;
        end
      endcase
    end
  end

  // Output window register: a qualifying write wins over a plain consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_row_r   <= ROW_ZERO;
      out_col_r   <= COL_ZERO;
      out_last_r  <= 1'b0;
    end else if (qual_s) begin
      out_valid_r <= 1'b1;
      out_row_r   <= wr_row_s;
      out_col_r   <= wr_col_s;
      out_last_r  <= frame_end_s;
    end else if (consume_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

`ifdef WINDOW_STREAM_CTRL_STATS_EN
  logic [15:0] stat_drop_r;
  logic [15:0] stat_frames_r;

  // Saturating counters for discarded idle words and completed frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_drop_r   <= 16'h0000;
      stat_frames_r <= 16'h0000;
    end else begin
      if ((state_r == IDLE) && in_valid && !in_sof && (stat_drop_r != 16'hFFFF)) begin
        stat_drop_r <= stat_drop_r + 16'd1;
      end
      if (frame_done_r && (stat_frames_r != 16'hFFFF)) begin
        stat_frames_r <= stat_frames_r + 16'd1;
      end
    end
  end

  assign stat_drop   = stat_drop_r;
  assign stat_frames = stat_frames_r;
`endif

  assign in_ready   = in_ready_s;
  assign write_en   = write_s;
  assign out_valid  = out_valid_r;
  assign out_row    = out_row_r;
  assign out_col    = out_col_r;
  assign out_last   = out_last_r;
  assign frame_done = frame_done_r;
  assign sof_err    = sof_err_r;

endmodule

// File: tb/tb_window_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_window_stream_ctrl
//   Self-checking bench for window_stream_ctrl with a 78x4 frame. An IDLE
//   vector table is followed by hand sequences. Expected windows come from a
//   bench-side position model, which pushes them to a scoreboard that a
//   negedge monitor drains.
// -----------------------------------------------------------------------------
module tb_window_stream_ctrl;

  localparam int W  = 78;
  localparam int H  = 4;
  localparam int CW = 7;
  localparam int RW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic          write_en;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;
  logic          frame_done;
  logic          sof_err;
`ifdef WINDOW_STREAM_CTRL_STATS_EN
  logic [15:0]   stat_drop;
  logic [15:0]   stat_frames;
`endif

  window_stream_ctrl #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .COL_W     (CW),
    .ROW_W     (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .write_en   (write_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .frame_done (frame_done),
    .sof_err    (sof_err)
`ifdef WINDOW_STREAM_CTRL_STATS_EN
    ,
    .stat_drop  (stat_drop),
    .stat_frames(stat_frames)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          last;
  } win_t;

  typedef struct {
    logic iv;
    logic sof;
    logic ordy;
    logic e_ir;
    logic e_we;
    logic e_ov;
  } vec_t;

  win_t sb_q[$];
  win_t mon_e;
  int   tests    = 0;
  int   fails    = 0;
  int   win_cnt  = 0;
  int   last_cnt = 0;
  int   m_r      = 0;
  int   m_c      = 0;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: every window handed over (valid & ready) is matched in order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      win_cnt++;
      if (out_last) last_cnt++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL win_unexpected: got (%0d,%0d), required no window", out_row, out_col);
      end else begin
        mon_e = sb_q.pop_front();
        chk("win_row", 32'(out_row), 32'(mon_e.r));
        chk("win_col", 32'(out_col), 32'(mon_e.c));
        chk("win_last", 32'(out_last), 32'(mon_e.last));
      end
    end
  end

  // Drive one word for a cycle; the bench model predicts its window.
  task automatic send(input bit sof);
    win_t e;
    if (sof) begin
      m_r = 0;
      m_c = 0;
    end
    in_valid = 1'b1;
    in_sof   = sof;
    if (m_r >= 2 && m_c >= 1) begin
      e.r    = RW'(m_r);
      e.c    = CW'(m_c);
      e.last = (m_r == H - 1) && (m_c == W - 1);
      sb_q.push_back(e);
    end
    @(negedge clk);
    chk("accept_ready", 32'(in_ready), 32'd1);
    chk("accept_wen", 32'(write_en), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (m_c == W - 1) begin
      m_c = 0;
      m_r = (m_r == H - 1) ? 0 : m_r + 1;
    end else begin
      m_c++;
    end
  endtask

  // Final window then frame_done pulse; called right after the (H-1,W-1) write.
  task automatic drain_check();
    chk("drain_valid", 32'(out_valid), 32'd1);
    chk("drain_last", 32'(out_last), 32'd1);
    chk("drain_ready", 32'(in_ready), 32'd0);
    chk("drain_fd0", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    chk("frame_done", 32'(frame_done), 32'd1);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("frame_done_pulse", 32'(frame_done), 32'd0);
  endtask

  task automatic frame_full();
    win_cnt  = 0;
    last_cnt = 0;
    send(1'b1);
    for (int i = 1; i < W * H; i++) begin
      send(1'b0);
      if (i == 2 * W) chk("pre_first_valid", 32'(out_valid), 32'd0);
      if (i == 2 * W + 1) begin
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_row", 32'(out_row), 32'd2);
        chk("first_col", 32'(out_col), 32'd1);
      end
    end
    drain_check();
    chk("win_count", 32'(win_cnt), 32'((H - 2) * (W - 1)));
    chk("last_count", 32'(last_cnt), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_row", 32'(out_row), 32'd0);
    chk("rst_col", 32'(out_col), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_sof_err", 32'(sof_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wen", 32'(write_en), 32'd0);

    // IDLE vectors: non-sof words are taken and dropped, never written.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      in_valid  = tbl[i].iv;
      in_sof    = tbl[i].sof;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      chk("idle_ready", 32'(in_ready), 32'(tbl[i].e_ir));
      chk("idle_wen", 32'(write_en), 32'(tbl[i].e_we));
      chk("idle_valid", 32'(out_valid), 32'(tbl[i].e_ov));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    chk("idle_after_valid", 32'(out_valid), 32'd0);
`ifdef WINDOW_STREAM_CTRL_STATS_EN
    chk("stat_drop", 32'(stat_drop), 32'd5);
`endif

    // Full frame with continuous flow.
    frame_full();
`ifdef WINDOW_STREAM_CTRL_STATS_EN
    chk("stat_frames", 32'(stat_frames), 32'd1);
`endif
    chk("no_sof_err", 32'(sof_err), 32'd0);

    // Mid-frame sof at (1,40) restarts the frame and latches sof_err.
    send(1'b1);
    repeat (W + 39) send(1'b0);
    chk("pre_sof_err", 32'(sof_err), 32'd0);
    send(1'b1);
    chk("sof_err_set", 32'(sof_err), 32'd1);
    repeat (2 * W + 1) send(1'b0);
    chk("restart_valid", 32'(out_valid), 32'd1);
    chk("restart_row", 32'(out_row), 32'd2);
    chk("restart_col", 32'(out_col), 32'd1);

    // Backpressure: window (2,1) held for 10 cycles with a word waiting.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_wen", 32'(write_en), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_row", 32'(out_row), 32'd2);
      chk("hold_col", 32'(out_col), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(1'b0);
    chk("release_valid", 32'(out_valid), 32'd1);
    chk("release_col", 32'(out_col), 32'd2);

    // Column wrap: (2,77) valid, (3,0) none, (3,1) valid.
    repeat (W - 3) send(1'b0);
    chk("wrap_a_valid", 32'(out_valid), 32'd1);
    chk("wrap_a_row", 32'(out_row), 32'd2);
    chk("wrap_a_col", 32'(out_col), 32'(W - 1));
    send(1'b0);
    chk("wrap_b_valid", 32'(out_valid), 32'd0);
    send(1'b0);
    chk("wrap_c_valid", 32'(out_valid), 32'd1);
    chk("wrap_c_row", 32'(out_row), 32'd3);
    chk("wrap_c_col", 32'(out_col), 32'd1);
    repeat (W - 2) send(1'b0);
    drain_check();
    chk("sof_err_sticky", 32'(sof_err), 32'd1);
    chk("sb_empty_b", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset mid-frame at (2,30) with a window pending.
    send(1'b1);
    repeat (2 * W + 30) send(1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_col", 32'(out_col), 32'd30);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_row", 32'(out_row), 32'd0);
    chk("arst_col", 32'(out_col), 32'd0);
    chk("arst_idle", 32'(in_ready), 32'd1);
    chk("arst_sof_err", 32'(sof_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    frame_full();
`ifdef WINDOW_STREAM_CTRL_STATS_EN
    chk("stat_frames_rst", 32'(stat_frames), 32'd1);
    chk("stat_drop_rst", 32'(stat_drop), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
